fpga_cfg_loader: RTL and testbench

Wishbone slave that loads the eFPGA fabric configuration chain from the Caravel management core. Firmware writes a bit count, streams 32-bit bitstream words into a small FIFO, then starts the transfer. An FSM shifts the words serially into the fabric's scan chain, pulses a latch strobe, and releases fabric reset. The block sits beside ariel_fpga_top inside user_project_wrapper, on the same wb_clk_i domain.

---
 rtl/fpga_cfg_pkg.sv | 34 +++
 rtl/cfg_fifo.sv | 48 ++++
 rtl/fpga_cfg_loader.sv | 173 +++++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// rtl/fpga_cfg_pkg.sv - shared constants, FSM states and CRC step for the eFPGA config loader
package fpga_cfg_pkg;

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_LEN    = 3'd1;
  localparam logic [2:0] OFF_DATA   = 3'd2;
  localparam logic [2:0] OFF_STATUS = 3'd3;
  localparam logic [2:0] OFF_CRC    = 3'd4;

  localparam int CTRL_START   = 0;
  localparam int CTRL_ABORT   = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVF     = 2;
  localparam int STAT_LVL_LSB = 4;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_DONE
  } cfg_state_e;

  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    crc16_step = {crc[14:0], 1'b0} ^ ((crc[15] ^ bit_in) ? CRC_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/cfg_fifo.sv
// rtl/cfg_fifo.sv - synchronous show-ahead FIFO with flush, full/empty and fill level
module cfg_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level   = wr_ptr - rd_ptr;
  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/fpga_cfg_loader.sv
// rtl/fpga_cfg_loader.sv - Wishbone loader that shifts a FIFO-fed bitstream into the eFPGA scan chain; FPGA_CFG_CRC_EN adds a chain CRC at offset 4
module fpga_cfg_loader
  import fpga_cfg_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4,
  parameter int          LEN_W      = 20
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        cfg_shift_en,
  output logic        cfg_data,
  output logic        cfg_latch,
  output logic        fabric_rst,
  output logic        cfg_irq
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

  cfg_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, cnt_q;
  logic [31:0]      sr_q, rd_mux;
  logic [4:0]       idx_q;
  logic             start_q, abort_q, irq_en_q, done_q, ovf_q, fab_rst_q, irq_q;
  logic             hit, wr_en, busy, push_req, start_go, ctrl_wr, stat_wr;
  logic             pop, shift_en, shift_bit, latch_pulse;
  logic [2:0]       off;
  logic [31:0]      fifo_dout;
  logic             fifo_full, fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  logic             unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];
  assign off      = wbs_adr_i[4:2];
  assign hit      = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
  assign wr_en    = hit & wbs_we_i;
  assign ctrl_wr  = wr_en && (off == OFF_CTRL) && wbs_sel_i[0];
  assign stat_wr  = wr_en && (off == OFF_STATUS) && wbs_sel_i[0];
  assign push_req = wr_en && (off == OFF_DATA) && (wbs_sel_i == 4'hF);
  assign busy     = (state_q != ST_IDLE);
  assign start_go = (state_q == ST_IDLE) && start_q && !abort_q;

  cfg_fifo #(.WIDTH(32), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(wb_clk_i), .rst(wb_rst_i), .flush(abort_q), .push(push_req), .din(wbs_dat_i),
    .pop(pop), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty), .level(fifo_level)
  );

  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    shift_en    = 1'b0;
    shift_bit   = 1'b0;
    latch_pulse = 1'b0;
    if (abort_q) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_q) state_d = (len_q == '0) ? ST_LATCH : ST_LOAD;
        ST_LOAD:  if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_SHIFT;
                  end
        ST_SHIFT: begin
                    shift_en  = 1'b1;
                    shift_bit = sr_q[0];
                    if (cnt_q == LEN_W'(1))  state_d = ST_LATCH;
                    else if (idx_q == 5'd31) state_d = ST_LOAD;
                  end
        ST_LATCH: begin
                    latch_pulse = 1'b1;
                    state_d     = ST_DONE;
                  end
        ST_DONE:  state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      cnt_q     <= '0;
      sr_q      <= '0;
      idx_q     <= '0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      fab_rst_q <= 1'b1;
      irq_q     <= 1'b0;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      state_q <= state_d;
      start_q <= ctrl_wr && wbs_dat_i[CTRL_START];
      abort_q <= ctrl_wr && wbs_dat_i[CTRL_ABORT];
      if (ctrl_wr) irq_en_q <= wbs_dat_i[CTRL_IRQ_EN];
      // start_q pending counts as busy: the FSM has not left IDLE yet.
      if (wr_en && (off == OFF_LEN) && !busy && !start_q)
        for (int i = 0; i < LEN_W; i++)
          if (wbs_sel_i[i/8]) len_q[i] <= wbs_dat_i[i];
      if (push_req && fifo_full) ovf_q <= 1'b1;
      else if (stat_wr && wbs_dat_i[STAT_OVF]) ovf_q <= 1'b0;
      if (stat_wr && wbs_dat_i[STAT_DONE]) done_q <= 1'b0;
      if (start_go) begin
        done_q    <= 1'b0;
        fab_rst_q <= 1'b1;
        cnt_q     <= len_q;
      end
      if (pop) begin
        sr_q  <= fifo_dout;
        idx_q <= '0;
      end
      if (shift_en) begin
        sr_q  <= sr_q >> 1;
        cnt_q <= cnt_q - LEN_W'(1);
        idx_q <= idx_q + 5'd1;
      end
      if (state_q == ST_DONE && !abort_q) begin
        done_q    <= 1'b1;
        fab_rst_q <= 1'b0;
      end
      if (abort_q) fab_rst_q <= 1'b1;
      irq_q     <= done_q & irq_en_q;
      wbs_ack_o <= hit;
      wbs_dat_o <= (hit && !wbs_we_i) ? rd_mux : 32'h0;
    end
  end

`ifdef FPGA_CFG_CRC_EN
  logic [15:0] crc_q;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)      crc_q <= '0;
    else if (start_go) crc_q <= CRC_INIT;
    else if (shift_en) crc_q <= crc16_step(crc_q, shift_bit);
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (off)
      OFF_CTRL:   rd_mux[CTRL_IRQ_EN] = irq_en_q;
      OFF_LEN:    rd_mux[LEN_W-1:0]   = len_q;
      OFF_STATUS: begin
                    rd_mux[STAT_BUSY]        = busy;
                    rd_mux[STAT_DONE]        = done_q;
                    rd_mux[STAT_OVF]         = ovf_q;
                    rd_mux[STAT_LVL_LSB +: 4] = 4'(fifo_level);
                  end
`ifdef FPGA_CFG_CRC_EN
      OFF_CRC:    rd_mux[15:0] = crc_q;
`endif
      default:    rd_mux = '0;
    endcase
  end

  assign cfg_shift_en = shift_en;
  assign cfg_data     = shift_bit;
  assign cfg_latch    = latch_pulse;
  assign fabric_rst   = fab_rst_q;
  assign cfg_irq      = irq_q;

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// tb/tb_fpga_cfg_loader.sv - directed scoreboard bench for fpga_cfg_loader (CRC read checked when FPGA_CFG_CRC_EN is defined)
module tb_fpga_cfg_loader;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        wbs_stb_i, wbs_cyc_i, wbs_we_i;
  logic [3:0]  wbs_sel_i;
  logic [31:0] wbs_dat_i, wbs_adr_i;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic        cfg_shift_en, cfg_data, cfg_latch, fabric_rst, cfg_irq;

  always #5 wb_clk_i = ~wb_clk_i;

  fpga_cfg_loader dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_dat_i(wbs_dat_i), .wbs_adr_i(wbs_adr_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .cfg_shift_en(cfg_shift_en), .cfg_data(cfg_data), .cfg_latch(cfg_latch),
    .fabric_rst(fabric_rst), .cfg_irq(cfg_irq)
  );

  localparam logic [31:0] BASE = 32'h3000_0000;

  int   checks = 0;
  int   errors = 0;
  bit   exp_q[$];
  logic [15:0] crc_m;

  logic obs_bit [0:1023];
  int   obs_cyc [0:1023];
  int   obs_n = 0;
  int   latch_n = 0;
  int   cyc = 0;

  always @(negedge wb_clk_i) begin
    cyc <= cyc + 1;
    if (cfg_shift_en && obs_n < 1024) begin
      obs_bit[obs_n] <= cfg_data;
      obs_cyc[obs_n] <= cyc;
      obs_n          <= obs_n + 1;
    end
    if (cfg_latch) latch_n <= latch_n + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] rdata, output int lat);
    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr; wbs_dat_i = dat; wbs_sel_i = sel;
    lat = 0;
    do begin
      @(posedge wb_clk_i); #1;
      lat++;
    end while (!wbs_ack_o && lat < 8);
    rdata = wbs_dat_o;
    chk("ack_seen", wbs_ack_o, 1'b1);
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] r;
    int l;
    xfer(1'b1, BASE | {27'd0, off, 2'b00}, d, sel, r, l);
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] d);
    int l;
    xfer(1'b0, BASE | {27'd0, off, 2'b00}, 32'h0, 4'hF, d, l);
  endtask

  task automatic rd_chk(input logic [2:0] off, input logic [31:0] exp, input string tag);
    logic [31:0] d;
    rd(off, d);
    chk(tag, d, exp);
  endtask

  task automatic exp_word(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(w[i]);
      crc_m = {crc_m[14:0], 1'b0} ^ ((crc_m[15] ^ w[i]) ? 16'h1021 : 16'h0000);
    end
  endtask

  task automatic wait_bits(input int base, input int n, input string tag);
    int k = 0;
    while (obs_n - base < n && k < 600) begin
      @(posedge wb_clk_i); #1;
      k++;
    end
    chk(tag, 32'(obs_n - base >= n), 1);
  endtask

  task automatic wait_latch(input int lbase, input string tag);
    int k = 0;
    while (latch_n == lbase && k < 600) begin
      @(posedge wb_clk_i); #1;
      k++;
    end
    chk(tag, 32'(latch_n - lbase), 1);
  endtask

  task automatic cmp_bits(input int base, input int n, input string tag);
    bit e;
    for (int i = 0; i < n; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      chk(tag, {31'd0, obs_bit[base + i]}, {31'd0, e});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int lat, base, lbase, n_abort;
    bit seen;

    wbs_stb_i = 0; wbs_cyc_i = 0; wbs_we_i = 0; wbs_sel_i = 0; wbs_dat_i = 0; wbs_adr_i = 0;
    wb_rst_i = 1'b1;
    repeat (3) @(posedge wb_clk_i);
    #1 wb_rst_i = 1'b0;

    // Reset state and bus timing
    chk("rst_fabric_rst", fabric_rst, 1'b1);
    chk("rst_shift_en", cfg_shift_en, 1'b0);
    chk("rst_latch", cfg_latch, 1'b0);
    chk("rst_irq", cfg_irq, 1'b0);
    xfer(1'b0, BASE | 32'hC, 32'h0, 4'hF, d, lat);
    chk("ack_latency", lat, 1);
    chk("status_rst", d, 32'h0);
    @(posedge wb_clk_i); #1;
    chk("ack_one_cycle", wbs_ack_o, 1'b0);
    rd_chk(3'd0, 32'h0, "ctrl_rst");
    rd_chk(3'd1, 32'h0, "len_rst");
    rd_chk(3'd5, 32'h0, "unmapped_5");

    @(posedge wb_clk_i); #1;
    wbs_stb_i = 1; wbs_cyc_i = 1; wbs_we_i = 0; wbs_sel_i = 4'hF; wbs_adr_i = 32'h3000_100C;
    seen = 0;
    repeat (4) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) seen = 1;
    end
    wbs_stb_i = 0; wbs_cyc_i = 0;
    chk("no_ack_foreign", seen, 1'b0);

    // Two words, 40 bits
    wr(3'd1, 32'd40, 4'hF);
    rd_chk(3'd1, 32'd40, "len_rb");
    wr(3'd2, 32'hA5A5_A5A5, 4'hF);
    wr(3'd2, 32'h0000_00FF, 4'hF);
    crc_m = 16'hFFFF;
    exp_word(32'hA5A5_A5A5, 32);
    exp_word(32'h0000_00FF, 8);
    base = obs_n; lbase = latch_n;
    wr(3'd0, 32'h1, 4'hF);
    wait_latch(lbase, "t2_latch");
    repeat (4) @(posedge wb_clk_i); #1;
    chk("t2_nbits", obs_n - base, 40);
    cmp_bits(base, 40, "t2_bit");
    chk("t2_bubble", obs_cyc[base + 32] - obs_cyc[base + 31], 2);
    chk("t2_no_bubble", obs_cyc[base + 31] - obs_cyc[base + 30], 1);
    chk("t2_one_latch", latch_n - lbase, 1);
    chk("t2_fabric_rst", fabric_rst, 1'b0);
    rd_chk(3'd3, 32'h2, "t2_status");
`ifdef FPGA_CFG_CRC_EN
    rd_chk(3'd4, {16'h0, crc_m}, "t2_crc");
`else
    rd_chk(3'd4, 32'h0, "t2_crc_off");
`endif

    // Underrun stall then resume
    wr(3'd1, 32'd64, 4'hF);
    wr(3'd2, 32'h1234_5678, 4'hF);
    crc_m = 16'hFFFF;
    exp_word(32'h1234_5678, 32);
    exp_word(32'hCAFE_F00D, 32);
    base = obs_n; lbase = latch_n;
    wr(3'd0, 32'h1, 4'hF);
    wait_bits(base, 32, "t3_first_word");
    repeat (6) @(posedge wb_clk_i); #1;
    chk("t3_stall_count", obs_n - base, 32);
    chk("t3_stall_shift_en", cfg_shift_en, 1'b0);
    rd_chk(3'd3, 32'h1, "t3_status_stall");
    wr(3'd2, 32'hCAFE_F00D, 4'hF);
    wait_latch(lbase, "t3_latch");
    repeat (4) @(posedge wb_clk_i); #1;
    chk("t3_nbits", obs_n - base, 64);
    cmp_bits(base, 64, "t3_bit");
    rd_chk(3'd3, 32'h2, "t3_status");

    // Overflow, W1C, abort flush
    for (int i = 0; i < 5; i++) wr(3'd2, 32'h100 + i, 4'hF);
    rd_chk(3'd3, 32'h46, "t4_full_ovf");
    wr(3'd3, 32'h4, 4'hF);
    rd_chk(3'd3, 32'h42, "t4_ovf_clr");
    wr(3'd0, 32'h2, 4'hF);
    rd_chk(3'd3, 32'h02, "t4_flushed");
    chk("t4_abort_fabric_rst", fabric_rst, 1'b1);

    // Abort mid-shift
    wr(3'd1, 32'd64, 4'hF);
    wr(3'd2, 32'h0F0F_3C3C, 4'hF);
    wr(3'd2, 32'h8000_0001, 4'hF);
    exp_word(32'h0F0F_3C3C, 32);
    exp_word(32'h8000_0001, 32);
    base = obs_n; lbase = latch_n;
    wr(3'd0, 32'h1, 4'hF);
    wait_bits(base, 10, "t5_ten_bits");
    wr(3'd1, 32'd5, 4'hF);
    wr(3'd0, 32'h2, 4'hF);
    @(posedge wb_clk_i); #1;
    chk("t5_idle_next", cfg_shift_en, 1'b0);
    @(posedge wb_clk_i); #1;
    n_abort = obs_n - base;
    repeat (5) @(posedge wb_clk_i); #1;
    chk("t5_stopped", obs_n - base, n_abort);
    chk("t5_partial", 32'(n_abort < 64), 1);
    cmp_bits(base, n_abort, "t5_bit");
    exp_q.delete();
    chk("t5_no_latch", latch_n - lbase, 0);
    chk("t5_fabric_rst", fabric_rst, 1'b1);
    rd_chk(3'd3, 32'h0, "t5_status");
    rd_chk(3'd1, 32'd64, "t5_len_locked");

    // Zero-length load with interrupt
    wr(3'd1, 32'd0, 4'hF);
    wr(3'd0, 32'h5, 4'hF);
    @(negedge wb_clk_i);
    chk("t6_latch_early", cfg_latch, 1'b0);
    @(negedge wb_clk_i);
    chk("t6_latch_at_2", cfg_latch, 1'b1);
    repeat (4) @(posedge wb_clk_i); #1;
    chk("t6_irq", cfg_irq, 1'b1);
    chk("t6_fabric_rst", fabric_rst, 1'b0);
`ifdef FPGA_CFG_CRC_EN
    rd_chk(3'd4, 32'h0000_FFFF, "t6_crc");
`else
    rd_chk(3'd4, 32'h0, "t6_crc_off");
`endif
    rd_chk(3'd0, 32'h4, "t6_ctrl");
    rd_chk(3'd3, 32'h2, "t6_status");
    wr(3'd3, 32'h2, 4'hF);
    repeat (3) @(posedge wb_clk_i); #1;
    chk("t6_irq_clear", cfg_irq, 1'b0);
    rd_chk(3'd3, 32'h0, "t6_status_clr");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
